fir_sequencer: RTL

Control unit for the FIR filter's shared multiply-accumulate datapath. It takes coefficient-write requests from the coefficient loader and sample arrivals from the AHB-Lite slave, then issues the one-hot strobes that drive the datapath: coefficient write, sample shift, accumulator clear, MAC per tap, and result valid. It also reports busy status (`modwait`) and arithmetic errors (`err`) back to the slave's status register.

---
 rtl/fir_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/fir_sequencer.sv
// Control FSM for the FIR filter's shared MAC datapath: coefficient writes, sample shift, per-tap MAC, result/error status.
// Optional one-entry sample pending flag enabled by defining FIR_SEQ_PENDING_EN.
module fir_sequencer #(
  parameter int TAP_BITS = 2
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                data_ready,
  input  logic                load_coeff,
  input  logic [TAP_BITS-1:0] coefficient_num,
  input  logic                overflow,
  output logic                modwait,
  output logic                err,
  output logic                coeff_we,
  output logic                shift_sample,
  output logic                acc_clear,
  output logic                mac_en,
  output logic [TAP_BITS-1:0] coeff_sel,
  output logic                result_valid,
  output logic                sample_lost
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_C,
    SHIFT,
    CLR,
    MAC,
    DONE,
    ERROR
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [TAP_BITS-1:0] tap;
  logic [TAP_BITS-1:0] next_tap;
  logic                pending;
  logic                idle_like;
  logic                lost;

  assign idle_like = (state == IDLE) || (state == ERROR);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      tap   <= '0;
    end else begin
      state <= next_state;
      tap   <= next_tap;
    end
  end

  // The tap counter doubles as the latched coefficient index during LOAD_C,
  // so coeff_sel stays a pure function of registered state.
  always_comb begin
    next_state = state;
    next_tap   = tap;
    case (state)
      IDLE, ERROR: begin
        if (load_coeff) begin
          next_state = LOAD_C;
          next_tap   = coefficient_num;
        end else if (data_ready || pending) begin
          next_state = SHIFT;
        end
      end
      LOAD_C: next_state = IDLE;
      SHIFT:  next_state = CLR;
      CLR: begin
        next_state = MAC;
        next_tap   = '0;
      end
      MAC: begin
        if (overflow) begin
          next_state = ERROR;
        end else if (tap == '1) begin
          next_state = DONE;
        end else begin
          next_tap = tap + 1'b1;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

`ifdef FIR_SEQ_PENDING_EN
  logic next_pending;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pending <= 1'b0;
    end else begin
      pending <= next_pending;
    end
  end

  // A pulse seen while SHIFT consumes the old entry simply takes its place.
  always_comb begin
    next_pending = pending | data_ready;
    if (state == SHIFT) begin
      next_pending = data_ready;
    end else if (idle_like && !load_coeff) begin
      next_pending = pending;
    end
  end

  assign lost = data_ready && pending && (state != SHIFT);
`else
  assign pending = 1'b0;
  assign lost    = data_ready && !(idle_like && !load_coeff);
`endif

  assign sample_lost = n_rst && lost;

  always_comb begin
    modwait      = 1'b0;
    err          = 1'b0;
    coeff_we     = 1'b0;
    shift_sample = 1'b0;
    acc_clear    = 1'b0;
    mac_en       = 1'b0;
    coeff_sel    = '0;
    result_valid = 1'b0;
    case (state)
      LOAD_C: begin
        modwait   = 1'b1;
        coeff_we  = 1'b1;
        coeff_sel = tap;
      end
      SHIFT: begin
        modwait      = 1'b1;
        shift_sample = 1'b1;
      end
      CLR: begin
        modwait   = 1'b1;
        acc_clear = 1'b1;
      end
      MAC: begin
        modwait   = 1'b1;
        mac_en    = 1'b1;
        coeff_sel = tap;
      end
      DONE: begin
        modwait      = 1'b1;
        result_valid = 1'b1;
      end
      ERROR:   err = 1'b1;
      default: ;
    endcase
  end

endmodule
